// File: rtl/cache_pkg.sv
// Shared types for the cache request front end: queued request record and FSM states.
package cache_pkg;
  localparam int WIDTH     = 8;
  localparam int RAM_DEPTH = 256;
  localparam int AW        = $clog2(RAM_DEPTH);

  typedef struct packed {
    logic           we;
    logic [AW-1:0]  addr;
    logic [WIDTH-1:0] data;
  } cache_req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} creq_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO of arbitrary element type; combinational head read, async reset.
module sync_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  T                       din,
  input  logic                   pop,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cache_req_queue.sv
// uP-side request queue for the cache: buffers requests, issues one at a time,
// returns each result over valid/ready, and times out a silent cache.
module cache_req_queue #(
  parameter int WIDTH     = 8,
  parameter int RAM_DEPTH = 256,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [$clog2(RAM_DEPTH)-1:0] req_addr,
  input  logic [WIDTH-1:0]             req_data,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_we,
  output logic [WIDTH-1:0]             rsp_data,
  output logic                         rsp_err,
  output logic                         cache_we,
  output logic                         cache_re,
  output logic [$clog2(RAM_DEPTH)-1:0] cache_addr,
  output logic [WIDTH-1:0]             cache_data,
  input  logic                         cache_done,
  input  logic [WIDTH-1:0]             cache_rdata,
  output logic                         busy
);
  import cache_pkg::*;

  localparam int CW = $clog2(TIMEOUT+1);

  creq_state_t             state, state_nxt;
  cache_req_t              fifo_din, fifo_dout, cur, cur_nxt;
  logic                    fifo_pop, fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic [CW-1:0]           tmo_cnt, tmo_nxt;
  logic                    we_nxt, re_nxt;
  logic                    rsp_valid_nxt, rsp_we_nxt, rsp_err_nxt;
  logic [WIDTH-1:0]        rsp_data_nxt;

  assign fifo_din  = '{we: req_we, addr: req_addr, data: req_data};
  assign req_ready = !fifo_full;

  sync_fifo #(.T(cache_req_t), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The issue register doubles as the held cache address/data.
  assign cache_addr = cur.addr;
  assign cache_data = cur.data;
  assign busy       = (state != IDLE) || (fifo_count != '0);

  always_comb begin
    state_nxt     = state;
    fifo_pop      = 1'b0;
    cur_nxt       = cur;
    tmo_nxt       = tmo_cnt;
    we_nxt        = 1'b0;
    re_nxt        = 1'b0;
    rsp_valid_nxt = rsp_valid;
    rsp_we_nxt    = rsp_we;
    rsp_data_nxt  = rsp_data;
    rsp_err_nxt   = rsp_err;
    case (state)
      IDLE: if (!fifo_empty) begin
        fifo_pop  = 1'b1;
        cur_nxt   = fifo_dout;
        state_nxt = ISSUE;
      end
      ISSUE: begin
        we_nxt    = cur.we;
        re_nxt    = !cur.we;
        tmo_nxt   = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        // done has priority over a coincident timeout expiry
        if (cache_done) begin
          rsp_valid_nxt = 1'b1;
          rsp_we_nxt    = cur.we;
          rsp_data_nxt  = cur.we ? '0 : cache_rdata;
          rsp_err_nxt   = 1'b0;
          state_nxt     = RESP;
        end else if (tmo_cnt == CW'(TIMEOUT-1)) begin
          rsp_valid_nxt = 1'b1;
          rsp_we_nxt    = cur.we;
          rsp_data_nxt  = '0;
          rsp_err_nxt   = 1'b1;
          state_nxt     = RESP;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      RESP: if (rsp_ready) begin
        rsp_valid_nxt = 1'b0;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      tmo_cnt   <= '0;
      cache_we  <= 1'b0;
      cache_re  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur       <= cur_nxt;
      tmo_cnt   <= tmo_nxt;
      cache_we  <= we_nxt;
      cache_re  <= re_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_we    <= rsp_we_nxt;
      rsp_data  <= rsp_data_nxt;
      rsp_err   <= rsp_err_nxt;
    end
  end
endmodule

// File: tb/tb_cache_req_queue.sv
// Directed bench for cache_req_queue: vector table for single transactions plus
// hand sequences for back-pressure, timeout, stalled response and mid-flight reset.
module tb_cache_req_queue;
  localparam int WIDTH = 8, RAM_DEPTH = 256, AW = 8, DEPTH = 4, TIMEOUT = 64;

  logic             clk = 1'b0, rst = 1'b1;
  logic             req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [AW-1:0]    req_addr = '0;
  logic [WIDTH-1:0] req_data = '0;
  logic             rsp_valid, rsp_ready = 1'b0, rsp_we, rsp_err;
  logic [WIDTH-1:0] rsp_data;
  logic             cache_we, cache_re, cache_done = 1'b0, busy;
  logic [AW-1:0]    cache_addr;
  logic [WIDTH-1:0] cache_data, cache_rdata = '0;

  cache_req_queue #(.WIDTH(WIDTH), .RAM_DEPTH(RAM_DEPTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cache_we(cache_we), .cache_re(cache_re), .cache_addr(cache_addr),
    .cache_data(cache_data), .cache_done(cache_done), .cache_rdata(cache_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int re_cnt = 0, we_cnt = 0, both_cnt = 0;

  // Strobe counters sampled shortly after each active edge.
  always @(posedge clk) begin
    #2;
    if (cache_re) re_cnt++;
    if (cache_we) we_cnt++;
    if (cache_re && cache_we) both_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] rdata;
    int               dly;
    logic             exp_we;
    logic [WIDTH-1:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic we, input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
    int t = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_data = data;
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    chk("push_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_strobe(output int cyc);
    cyc = 0;
    while (!(cache_re || cache_we) && cyc < 100) begin @(negedge clk); cyc++; end
    chk("strobe_seen", cache_re | cache_we, 1);
  endtask

  task automatic done_pulse(input logic [WIDTH-1:0] rd);
    cache_done = 1'b1; cache_rdata = rd;
    @(negedge clk);
    cache_done = 1'b0; cache_rdata = '0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 0);
  endtask

  vec_t vecs[5];

  initial begin
    int cyc, r0, w0;
    vecs[0] = '{we:1'b0, addr:8'h05, data:8'h00, rdata:8'hA5, dly:3, exp_we:1'b0, exp_data:8'hA5};
    vecs[1] = '{we:1'b1, addr:8'h10, data:8'h3C, rdata:8'h77, dly:2, exp_we:1'b1, exp_data:8'h00};
    vecs[2] = '{we:1'b0, addr:8'hFF, data:8'h00, rdata:8'h00, dly:0, exp_we:1'b0, exp_data:8'h00};
    vecs[3] = '{we:1'b0, addr:8'h00, data:8'h00, rdata:8'hFF, dly:5, exp_we:1'b0, exp_data:8'hFF};
    vecs[4] = '{we:1'b1, addr:8'h80, data:8'hFF, rdata:8'h5A, dly:1, exp_we:1'b1, exp_data:8'h00};

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_outs", {rsp_valid, rsp_we, rsp_data, rsp_err, cache_we, cache_re, cache_addr, cache_data, busy}, 0);
    chk("rst_ready", req_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", {rsp_valid, cache_we, cache_re, busy}, 0);

    // done and rsp_ready while idle do nothing
    rsp_ready = 1'b1;
    done_pulse(8'hEE);
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("idle_done_ignored", {rsp_valid, busy, cache_re, cache_we}, 0);

    // Table of single transactions into an idle queue
    for (int i = 0; i < 5; i++) begin
      r0 = re_cnt; w0 = we_cnt;
      push(vecs[i].we, vecs[i].addr, vecs[i].data);
      wait_strobe(cyc);
      chk("strobe_latency", cyc, 2);
      chk("strobe_re", cache_re, !vecs[i].we);
      chk("strobe_we", cache_we, vecs[i].we);
      chk("issue_addr", cache_addr, vecs[i].addr);
      repeat (vecs[i].dly) @(negedge clk);
      chk("addr_held", cache_addr, vecs[i].addr);
      if (vecs[i].we) chk("data_held", cache_data, vecs[i].data);
      chk("no_early_rsp", rsp_valid, 0);
      done_pulse(vecs[i].rdata);
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_we", rsp_we, vecs[i].exp_we);
      chk("rsp_data", rsp_data, vecs[i].exp_data);
      chk("rsp_err", rsp_err, 0);
      chk("re_pulses", re_cnt - r0, vecs[i].we ? 0 : 1);
      chk("we_pulses", we_cnt - w0, vecs[i].we ? 1 : 0);
      handshake();
    end

    // Five back-to-back pushes against a stalled cache
    r0 = re_cnt;
    for (int k = 0; k < 5; k++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'(8'h40 + k); req_data = '0;
      chk("b2b_ready", req_ready, 1);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("full_ready", req_ready, 0);
    chk("full_busy", busy, 1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) wait_strobe(cyc);
      chk("order_addr", cache_addr, 8'(8'h40 + k));
      done_pulse(8'(8'hC0 + k));
      chk("order_valid", rsp_valid, 1);
      chk("order_data", rsp_data, 8'(8'hC0 + k));
      handshake();
    end
    chk("order_re_pulses", re_cnt - r0, 5);
    chk("drained_busy", busy, 0);

    // Silent cache times out, then the queued request is serviced
    push(1'b0, 8'h22, 8'h00);
    wait_strobe(cyc);
    push(1'b0, 8'h23, 8'h00);
    repeat (TIMEOUT - 2) @(negedge clk);
    chk("tmo_not_yet", rsp_valid, 0);
    @(negedge clk);
    chk("tmo_valid", rsp_valid, 1);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_data", rsp_data, 0);
    chk("tmo_we", rsp_we, 0);
    handshake();
    wait_strobe(cyc);
    chk("tmo_next_latency", cyc, 2);
    chk("tmo_next_addr", cache_addr, 8'h23);
    done_pulse(8'h5A);
    chk("tmo_next_err", rsp_err, 0);
    chk("tmo_next_data", rsp_data, 8'h5A);
    handshake();

    // done coincides with timeout expiry; rsp_ready already high beforehand
    push(1'b0, 8'h33, 8'h00);
    wait_strobe(cyc);
    repeat (TIMEOUT - 1) @(negedge clk);
    rsp_ready = 1'b1;
    chk("race_no_rsp", rsp_valid, 0);
    done_pulse(8'h99);
    chk("race_valid", rsp_valid, 1);
    chk("race_err", rsp_err, 0);
    chk("race_data", rsp_data, 8'h99);
    @(negedge clk);
    chk("race_auto_hs", rsp_valid, 0);
    rsp_ready = 1'b0;

    // Response held for 10 cycles; done during RESP is ignored
    push(1'b1, 8'h50, 8'hAB);
    push(1'b0, 8'h51, 8'h00);
    wait_strobe(cyc);
    chk("hold_first_we", cache_we, 1);
    done_pulse(8'h11);
    r0 = re_cnt; w0 = we_cnt;
    for (int i = 0; i < 10; i++) begin
      cache_done = (i == 4); cache_rdata = 8'h77;
      @(negedge clk);
      chk("hold_stable", {rsp_valid, rsp_we, rsp_err, rsp_data}, {1'b1, 1'b1, 1'b0, 8'h00});
    end
    cache_done = 1'b0; cache_rdata = '0;
    chk("hold_no_strobe", (re_cnt - r0) + (we_cnt - w0), 0);
    handshake();
    wait_strobe(cyc);
    chk("hold_next_latency", cyc, 2);
    chk("hold_next_addr", cache_addr, 8'h51);
    done_pulse(8'h42);
    chk("hold_next_data", rsp_data, 8'h42);
    handshake();

    // Reset while waiting on the cache with two more queued
    push(1'b0, 8'h60, 8'h00);
    push(1'b0, 8'h61, 8'h00);
    push(1'b0, 8'h62, 8'h00);
    wait_strobe(cyc);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_outs", {rsp_valid, rsp_we, rsp_data, rsp_err, cache_we, cache_re, cache_addr, cache_data, busy}, 0);
    chk("mid_rst_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    r0 = re_cnt; w0 = we_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {rsp_valid, cache_re, cache_we, busy}, 0);
    end
    chk("post_rst_strobes", (re_cnt - r0) + (we_cnt - w0), 0);
    chk("never_both", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
